mem_bus_loader: RTL and testbench
=================================

# mem_bus_loader

Bus initiator for the data-memory port: drives the same Address / Write_data / MemRead / MemWrite / Mem_data interface the CPU uses, so words can be loaded into, or dumped out of, data memory over a byte stream. It sits between the UART receive/transmit byte streams and the data-memory bus mux. It is used for program/data download and result readback while the CPU is held idle.

## Interface
Parameters:
- BASE_ADDR, 32'h00000000, byte address of word index 0.
- WORD_COUNT, 12, words per transfer; must be ≥ 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a transfer; sampled only in IDLE.
- mode  in  1  0 = load (bytes to memory), 1 = dump (memory to bytes); sampled with start.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- tx_data  out  8  outgoing byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  consumer accepts a byte this cycle.
- Address  out  32  memory byte address.
- Write_data  out  32  memory write word.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe; memory writes on the same rising edge.
- Mem_data  in  32  combinational read data from memory.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RX_BYTE, WRITE, RD, TX_BYTE, DONE.
- IDLE: all outputs 0. If start = 1, latch mode, clear word index idx and byte count bcnt, then go to RX_BYTE (mode 0) or RD (mode 1). start is ignored in every other state.
- RX_BYTE: rx_ready = 1. A byte is accepted when rx_valid & rx_ready. Bytes are assembled little-endian: the first byte goes to [7:0], the fourth to [31:24]. After the fourth accepted byte, go to WRITE.
- WRITE: lasts exactly 1 cycle. MemWrite = 1, Address = BASE_ADDR + 4·idx, Write_data = assembled word. Then increment idx. If idx was WORD_COUNT−1, go to DONE; otherwise go to RX_BYTE.
- RD: lasts exactly 1 cycle. MemRead = 1, Address = BASE_ADDR + 4·idx. Latch Mem_data into the tx word register at the clock edge, then go to TX_BYTE with bcnt = 0.
- TX_BYTE: tx_valid = 1, tx_data = byte bcnt of the latched word, little-endian. Advance bcnt on tx_valid & tx_ready. tx_data must stay stable while stalled. After the fourth accepted byte, increment idx. If the last word was sent, go to DONE; otherwise go to RD.
- DONE: done = 1 for 1 cycle, then go to IDLE.
- busy = 1 in every state except IDLE.
- Address, Write_data, MemRead and MemWrite are 0 outside WRITE/RD. MemRead and MemWrite are never both 1.
- Address arithmetic is 32-bit modulo 2^32, so BASE_ADDR near the top of the address space wraps to 0. The idx counter is wide enough to hold WORD_COUNT.
- Reset (reset = 0 at a rising edge) from any state:
  - return to IDLE and clear idx, bcnt and the word registers;
  - drive all outputs 0 on the following cycle;
  - discard any partial word;
  - words already written stay in memory.

## Timing
- start accepted at edge N: state RX_BYTE or RD and busy = 1 in cycle N+1.
- Load: MemWrite is asserted in the cycle immediately after the edge that accepts the fourth byte of a word. Minimum 5 cycles per word.
- Dump: RD cycle, then the first tx_valid in the next cycle. Minimum 5 cycles per word with tx_ready held at 1.
- done is asserted in the cycle after the final WRITE cycle, or after the final tx handshake edge.
- Back-to-back transfers: start can be accepted in the IDLE cycle that follows DONE.

## Test plan
- Reset held low for 2 cycles, with start = 1 and rx_valid = 1 → all outputs 0, busy = 0, rx_ready = 0, no MemWrite.
- Load, WORD_COUNT = 2, BASE_ADDR = 0, bytes 78 56 34 12 EF BE AD DE sent back-to-back → MemWrite at Address 0x0 with data 0x12345678, then at 0x4 with 0xDEADBEEF; done pulses 1 cycle after the second write; memory words 0 and 1 read back with those values.
- Dump, WORD_COUNT = 2, memory words 0 = 0x05 and 1 = 0x05, tx_ready low for 3 cycles on every second byte → bytes 05 00 00 00 05 00 00 00 in order; tx_data is unchanged while stalled; exactly 2 MemRead cycles occur.
- Load with rx_valid gaps of 0 to 4 cycles between bytes → each MemWrite falls exactly 1 cycle after its fourth byte; no write occurs early.
- start pulsed mid-transfer → ignored. Reset after 2 bytes of a load → IDLE, no MemWrite; a fresh load then writes word 0 at BASE_ADDR.
- BASE_ADDR = 0xFFFFFFFC, WORD_COUNT = 2, load → writes go to Address 0xFFFFFFFC, then 0x00000000.

Source files
------------

// File: rtl/mem_bus_loader.sv
// mem_bus_loader: byte-stream loader/dumper acting as a data-memory bus initiator.
// Ports: clk/reset, start/mode, rx_* stream in, tx_* stream out, memory bus, busy/done.
module mem_bus_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WORD_COUNT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Mem_data,
  output logic        busy,
  output logic        done
);

  localparam int IW = $clog2(WORD_COUNT + 1);
  localparam logic [IW-1:0] LAST = IW'(WORD_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_BYTE,
    WRITE,
    RD,
    TX_BYTE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_n;
  logic [1:0]    bcnt;
  logic [1:0]    bcnt_n;
  logic [31:0]   wword;
  logic [31:0]   wword_n;
  logic [31:0]   tword;
  logic [31:0]   tword_n;
  logic [31:0]   word_addr;

  // 32-bit wrap-around is intended.
  assign word_addr = BASE_ADDR + (32'(idx) << 2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      bcnt  <= '0;
      wword <= '0;
      tword <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      bcnt  <= bcnt_n;
      wword <= wword_n;
      tword <= tword_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    bcnt_n  = bcnt;
    wword_n = wword;
    tword_n = tword;
    unique case (state)
      IDLE: begin
        if (start) begin
          idx_n   = '0;
          bcnt_n  = '0;
          state_n = mode ? RD : RX_BYTE;
        end
      end
      RX_BYTE: begin
        if (rx_valid) begin
          wword_n[{bcnt, 3'b000} +: 8] = rx_data;
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        idx_n   = idx + IW'(1);
        state_n = (idx == LAST) ? DONE : RX_BYTE;
      end
      RD: begin
        tword_n = Mem_data;
        bcnt_n  = '0;
        state_n = TX_BYTE;
      end
      TX_BYTE: begin
        if (tx_ready) begin
          bcnt_n = bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            idx_n   = idx + IW'(1);
            state_n = (idx == LAST) ? DONE : RD;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    rx_ready   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    Address    = '0;
    Write_data = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    unique case (state)
      RX_BYTE: begin
        rx_ready = 1'b1;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        Address    = word_addr;
        Write_data = wword;
      end
      RD: begin
        MemRead = 1'b1;
        Address = word_addr;
      end
      TX_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = tword[{bcnt, 3'b000} +: 8];
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_loader.sv
// tb_mem_bus_loader: directed load/dump bench with a transaction-level model.
// Two instances: base 0 and base 0xFFFFFFFC, both with two words per transfer.
module tb_mem_bus_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;
  localparam int          WC    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start1;
  logic        mode;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;

  logic        rx_ready0, tx_valid0, MemRead0, MemWrite0, busy0, done0;
  logic [7:0]  tx_data0;
  logic [31:0] Address0, Write_data0, Mem_data0;
  logic        rx_ready1, tx_valid1, MemRead1, MemWrite1, busy1, done1;
  logic [7:0]  tx_data1;
  logic [31:0] Address1, Write_data1, Mem_data1;

  logic [31:0] mem [16];

  always #5 clk = ~clk;

  mem_bus_loader #(.BASE_ADDR(BASE0), .WORD_COUNT(WC)) dut0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready0),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .Address(Address0), .Write_data(Write_data0),
    .MemRead(MemRead0), .MemWrite(MemWrite0), .Mem_data(Mem_data0),
    .busy(busy0), .done(done0)
  );

  mem_bus_loader #(.BASE_ADDR(BASE1), .WORD_COUNT(WC)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
    .Address(Address1), .Write_data(Write_data1),
    .MemRead(MemRead1), .MemWrite(MemWrite1), .Mem_data(Mem_data1),
    .busy(busy1), .done(done1)
  );

  always @(posedge clk) begin
    if (MemWrite0) mem[Address0[5:2]] <= Write_data0;
  end
  assign Mem_data0 = mem[Address0[5:2]];
  assign Mem_data1 = 32'h0;

  int ntot = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic tmo(input string nm);
    ntot++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Model of dut0: what each output must be in the coming cycle.
  bit          armed = 0;
  bit          m_busy, m_ld, m_rxr, m_we, m_re, m_txv, m_done;
  int          m_idx, m_nb;
  logic [31:0] m_word, m_addr, m_wd;
  logic [7:0]  m_txq [$];
  logic [7:0]  got_tx [$];
  int          n_rd = 0;
  logic [31:0] w1_addr [$];
  logic [31:0] w1_data [$];
  int          n_done1 = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_tx;

  always @(negedge clk) begin
    logic [7:0]  etx;
    logic [31:0] w;
    if (armed) begin
      chkb("busy", busy0, m_busy);
      chkb("rx_ready", rx_ready0, m_rxr);
      chkb("MemWrite", MemWrite0, m_we);
      chkb("MemRead", MemRead0, m_re);
      chkb("tx_valid", tx_valid0, m_txv);
      chkb("done", done0, m_done);
      chk("Address", Address0, (m_we || m_re) ? m_addr : 32'h0);
      chk("Write_data", Write_data0, m_we ? m_wd : 32'h0);
      etx = 8'h00;
      if (m_txv && m_txq.size() > 0) etx = m_txq[0];
      chk("tx_data", {24'h0, tx_data0}, {24'h0, etx});
      if (prev_stall && tx_valid0)
        chk("tx_stable", {24'h0, tx_data0}, {24'h0, prev_tx});
      chkb("rw_excl", MemRead0 & MemWrite0, 1'b0);
      chkb("MemRead1", MemRead1, 1'b0);
      chkb("tx_valid1", tx_valid1, 1'b0);
      chk("tx_data1", {24'h0, tx_data1}, 32'h0);
      if (MemRead0) n_rd++;
      if (tx_valid0 && tx_ready) got_tx.push_back(tx_data0);
      if (MemWrite1) begin
        w1_addr.push_back(Address1);
        w1_data.push_back(Write_data1);
      end
      if (done1) n_done1++;
    end
    prev_stall = armed && tx_valid0 && !tx_ready;
    prev_tx    = tx_data0;

    if (!reset) begin
      armed  = 1;
      m_busy = 0; m_ld = 0; m_rxr = 0; m_we = 0; m_re = 0;
      m_txv  = 0; m_done = 0; m_idx = 0; m_nb = 0;
      m_word = '0; m_addr = '0; m_wd = '0;
      m_txq.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_ld = !mode; m_idx = 0; m_nb = 0;
        if (mode) begin
          m_re = 1;
          m_addr = BASE0;
        end else begin
          m_rxr = 1;
        end
      end
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_ld) begin
      if (m_we) begin
        m_we = 0;
        m_idx++;
        if (m_idx == WC) m_done = 1;
        else m_rxr = 1;
      end else if (rx_valid) begin
        m_word[8*m_nb +: 8] = rx_data;
        m_nb++;
        if (m_nb == 4) begin
          m_nb = 0; m_rxr = 0; m_we = 1;
          m_addr = BASE0 + 32'(m_idx) * 32'd4;
          m_wd = m_word;
        end
      end
    end else begin
      if (m_re) begin
        m_re = 0;
        w = mem[m_addr[5:2]];
        for (int k = 0; k < 4; k++) m_txq.push_back(w[8*k +: 8]);
        m_txv = 1;
      end else if (m_txv && tx_ready) begin
        void'(m_txq.pop_front());
        if (m_txq.size() == 0) begin
          m_txv = 0;
          m_idx++;
          if (m_idx == WC) m_done = 1;
          else begin
            m_re = 1;
            m_addr = BASE0 + 32'(m_idx) * 32'd4;
          end
        end
      end
    end
  end

  task automatic start_xfer(input logic m, input bit sel);
    mode = m;
    if (sel) start1 = 1'b1;
    else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0; mode = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit sel);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data = b; rx_valid = 1'b1; n = 0;
    @(negedge clk);
    while (!(sel ? rx_ready1 : rx_ready0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) tmo("rx_handshake");
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while (!(sel ? done1 : done0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) tmo("done_wait");
    @(posedge clk); #1;
  endtask

  task automatic tx_run();
    int n;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      while (!tx_valid0 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) tmo("tx_wait");
      if (b % 2 == 1) begin
        repeat (3) begin @(posedge clk); #1; end
      end
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
  endtask

  logic [7:0] ld1 [8]  = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] ld2 [8]  = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
  int         gaps [8] = '{0, 1, 2, 3, 4, 0, 2, 4};
  logic [7:0] ld3 [8]  = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
  logic [7:0] ld4 [8]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
  logic [7:0] exp_tx [8] = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b1; start1 = 1'b0; mode = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hAA; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_busy", busy0, 1'b0);
    chkb("rst_rx_ready", rx_ready0, 1'b0);
    chkb("rst_MemWrite", MemWrite0, 1'b0);
    chk("rst_Address", Address0, 32'h0);
    chkb("rst_done", done0, 1'b0);
    chkb("rst_busy1", busy1, 1'b0);
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0;
    @(posedge clk); #1;

    start_xfer(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(ld1[i], 0, 1'b0);
    wait_done(1'b0);
    chk("mem0_load", mem[0], 32'h1234_5678);
    chk("mem1_load", mem[1], 32'hDEAD_BEEF);

    start_xfer(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(ld2[i], gaps[i], 1'b0);
    wait_done(1'b0);
    chk("mem0_gap", mem[0], 32'h0000_0005);
    chk("mem1_gap", mem[1], 32'h0000_0005);

    n_rd = 0;
    got_tx.delete();
    start_xfer(1'b1, 1'b0);
    tx_run();
    wait_done(1'b0);
    chk("dump_nbytes", got_tx.size(), 32'd8);
    if (got_tx.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("dump_byte", {24'h0, got_tx[i]}, {24'h0, exp_tx[i]});
    chk("dump_reads", n_rd, 32'd2);

    start_xfer(1'b0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = 1'b0;
    send_byte(8'h22, 0, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chkb("abort_busy", busy0, 1'b0);
    chk("abort_mem0", mem[0], 32'h0000_0005);
    start_xfer(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(ld3[i], 0, 1'b0);
    wait_done(1'b0);
    chk("mem0_fresh", mem[0], 32'h1122_3344);
    chk("mem1_fresh", mem[1], 32'h5566_7788);

    start_xfer(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(ld4[i], 0, 1'b1);
    wait_done(1'b1);
    chk("wrap_nwrites", w1_addr.size(), 32'd2);
    if (w1_addr.size() == 2) begin
      chk("wrap_addr0", w1_addr[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", w1_addr[1], 32'h0000_0000);
      chk("wrap_data0", w1_data[0], 32'h0403_0201);
      chk("wrap_data1", w1_data[1], 32'h0D0C_0B0A);
    end
    chk("wrap_done", n_done1, 32'd1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
